// File: rtl/ptch_fusion_if.sv
// Sensor-side and controller-side signals of the pitch fusion integrator.
// Handshake: vld is a one-cycle strobe with no ready; every strobe is accepted, including back-to-back ones. ptch_vld is a one-cycle strobe toward the consumer.
interface ptch_fusion_if #(
  parameter int DATA_W = 16
) ();
  logic              vld;
  logic              clr;
  logic [DATA_W-1:0] ptch_rt;
  logic [DATA_W-1:0] AZ;
  logic [DATA_W-1:0] ptch;
  logic              ptch_vld;
  logic              settled;
  logic              sat;
  logic [1:0]        dbg_state;

  modport master (
    output vld, clr, ptch_rt, AZ,
    input  ptch, ptch_vld, settled, sat, dbg_state
  );

  modport slave (
    input  vld, clr, ptch_rt, AZ,
    output ptch, ptch_vld, settled, sat, dbg_state
  );
endinterface

// File: rtl/ptch_fusion_integrator.sv
// Two-stage gyro integrator with complementary fusion toward accel pitch, boosted settle phase and saturation.
// Define OFFSET_CAL_EN to add a CAL state that measures the gyro offset from 64 samples after reset/clr.
module ptch_fusion_integrator #(
  parameter int                DATA_W         = 16,
  parameter int                INT_SHIFT      = 11,
  parameter logic [DATA_W-1:0] PTCH_RT_OFFSET = DATA_W'('h0050),
  parameter logic [DATA_W-1:0] AZ_OFFSET      = DATA_W'('h00A0),
  parameter int                ACC_GAIN       = 327,
  parameter int                ACC_SHIFT      = 13,
  parameter int                FUSION_OFF     = 1024,
  parameter int                SETTLE_SHIFT   = 3,
  parameter int                SETTLE_SMPLS   = 256
) (
  input logic          clk,
  input logic          rst,
  ptch_fusion_if.slave io_bus
);
  localparam int ACC_W  = DATA_W + INT_SHIFT;
  localparam int SUM_W  = ACC_W + 2;
  localparam int PROD_W = DATA_W + 32;
  localparam int CNT_W  = $clog2(SETTLE_SMPLS + 1);

  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_RUN    = 2'd2;
`ifdef OFFSET_CAL_EN
  localparam logic [1:0] ST_CAL    = 2'd0;
  localparam logic [1:0] ST_INIT   = ST_CAL;
`else
  localparam logic [1:0] ST_INIT   = ST_SETTLE;
`endif

  localparam logic signed [PROD_W-1:0] GAIN_S   = PROD_W'(ACC_GAIN);
  localparam logic signed [SUM_W-1:0]  G_RUN    = SUM_W'(FUSION_OFF);
  localparam logic signed [SUM_W-1:0]  G_SETTLE = SUM_W'(FUSION_OFF << SETTLE_SHIFT);
  localparam logic signed [SUM_W-1:0]  ACC_MAX  = {3'b000, {(ACC_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0]  ACC_MIN  = {3'b111, {(ACC_W-1){1'b0}}};
  localparam logic [CNT_W-1:0]         CNT_LAST = CNT_W'(SETTLE_SMPLS - 1);

  logic [1:0]               r_state;
  logic [CNT_W-1:0]         r_cnt;
  logic                     r_settled;
  logic                     r_s1_vld;
  logic signed [DATA_W-1:0] r_rt_c;
  logic signed [DATA_W-1:0] r_acc_p;
  logic signed [ACC_W-1:0]  r_acc;
  logic signed [DATA_W-1:0] r_ptch;
  logic                     r_ptch_vld;
  logic                     r_sat;

  logic [DATA_W-1:0]        w_rt_off;
  logic                     w_s1_ok;
  logic signed [DATA_W-1:0] w_rt_c;
  logic signed [DATA_W-1:0] w_az_c;
  logic signed [PROD_W-1:0] w_prod;
  logic signed [DATA_W-1:0] w_acc_p;
  logic signed [SUM_W-1:0]  w_g;
  logic signed [SUM_W-1:0]  w_f;
  logic signed [SUM_W-1:0]  w_sum;
  logic                     w_hi;
  logic                     w_lo;
  logic signed [ACC_W-1:0]  w_acc_nxt;
  logic                     w_unused_bits;

`ifdef OFFSET_CAL_EN
  logic [DATA_W-1:0]        r_rt_off;
  logic signed [DATA_W+5:0] r_cal_sum;
  logic [5:0]               r_cal_cnt;
  logic signed [DATA_W+5:0] w_cal_sum_nxt;

  assign w_rt_off      = r_rt_off;
  assign w_s1_ok       = (r_state != ST_CAL);
  assign w_cal_sum_nxt = r_cal_sum + {{6{io_bus.ptch_rt[DATA_W-1]}}, io_bus.ptch_rt};
  assign w_unused_bits = ^{w_prod[ACC_SHIFT-1:0], w_prod[PROD_W-1:ACC_SHIFT+DATA_W],
                           w_cal_sum_nxt[5:0]};
`else
  assign w_rt_off      = PTCH_RT_OFFSET;
  assign w_s1_ok       = 1'b1;
  assign w_unused_bits = ^{w_prod[ACC_SHIFT-1:0], w_prod[PROD_W-1:ACC_SHIFT+DATA_W]};
`endif

  // Stage 1: offset compensation and accel-to-pitch scaling
  assign w_rt_c  = io_bus.ptch_rt - w_rt_off;
  assign w_az_c  = io_bus.AZ - AZ_OFFSET;
  assign w_prod  = w_az_c * GAIN_S;
  assign w_acc_p = w_prod[ACC_SHIFT +: DATA_W];

  // Stage 2: two guard bits so the sum can be range-checked before clamping
  assign w_g   = (r_state == ST_RUN) ? G_RUN : G_SETTLE;
  assign w_f   = (r_acc_p > r_ptch) ? w_g : -w_g;
  assign w_sum = $signed({{2{r_acc[ACC_W-1]}}, r_acc}) + w_f
               - $signed({{(SUM_W-DATA_W){r_rt_c[DATA_W-1]}}, r_rt_c});
  assign w_hi  = (w_sum > ACC_MAX);
  assign w_lo  = (w_sum < ACC_MIN);
  assign w_acc_nxt = w_hi ? ACC_MAX[ACC_W-1:0] :
                     w_lo ? ACC_MIN[ACC_W-1:0] : w_sum[ACC_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_INIT;
      r_cnt      <= '0;
      r_settled  <= 1'b0;
      r_s1_vld   <= 1'b0;
      r_rt_c     <= '0;
      r_acc_p    <= '0;
      r_acc      <= '0;
      r_ptch     <= '0;
      r_ptch_vld <= 1'b0;
      r_sat      <= 1'b0;
`ifdef OFFSET_CAL_EN
      r_rt_off   <= PTCH_RT_OFFSET;
      r_cal_sum  <= '0;
      r_cal_cnt  <= '0;
`endif
    end else if (io_bus.clr) begin
      r_state    <= ST_INIT;
      r_cnt      <= '0;
      r_settled  <= 1'b0;
      r_s1_vld   <= 1'b0;
      r_acc      <= '0;
      r_ptch     <= '0;
      r_ptch_vld <= 1'b0;
      r_sat      <= 1'b0;
`ifdef OFFSET_CAL_EN
      r_cal_sum  <= '0;
      r_cal_cnt  <= '0;
`endif
    end else begin
      r_s1_vld <= io_bus.vld && w_s1_ok;
      if (io_bus.vld) begin
        r_rt_c  <= w_rt_c;
        r_acc_p <= w_acc_p;
      end
`ifdef OFFSET_CAL_EN
      if ((r_state == ST_CAL) && io_bus.vld) begin
        r_cal_sum <= w_cal_sum_nxt;
        r_cal_cnt <= r_cal_cnt + 6'd1;
        if (r_cal_cnt == 6'd63) begin
          r_rt_off  <= w_cal_sum_nxt[DATA_W+5:6];
          r_cal_sum <= '0;
          r_state   <= ST_SETTLE;
        end
      end
`endif
      r_ptch_vld <= r_s1_vld;
      r_sat      <= r_s1_vld && (w_hi || w_lo);
      if (r_s1_vld) begin
        r_acc  <= w_acc_nxt;
        r_ptch <= w_acc_nxt[ACC_W-1 -: DATA_W];
        // The update that hits the last settle count still used the boosted gain above
        if (r_state == ST_SETTLE) begin
          if (r_cnt == CNT_LAST) begin
            r_state   <= ST_RUN;
            r_settled <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      end
    end
  end

  assign io_bus.ptch      = r_ptch;
  assign io_bus.ptch_vld  = r_ptch_vld;
  assign io_bus.settled   = r_settled;
  assign io_bus.sat       = r_sat;
  assign io_bus.dbg_state = r_state;
endmodule
